// File: rtl/prog_counter.sv
// Up/down counter-timer with prescaler, programmable terminal value and wrap/saturate/one-shot end modes.
// count, tc and done are registered and update on the edge that samples the clear, load or step.
module prog_counter #(
    parameter int WIDTH      = 8,
    parameter int PRESCALE_W = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  clear,
    input  logic                  load,
    input  logic [WIDTH-1:0]      load_value,
    input  logic                  up_down,
    input  logic [1:0]            mode,
    input  logic [WIDTH-1:0]      limit,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic [WIDTH-1:0]      count,
    output logic                  tc,
    output logic                  done
);

    localparam logic [1:0] MODE_SAT  = 2'b01;
    localparam logic [1:0] MODE_ONCE = 2'b10;

    logic [WIDTH-1:0]      count_q, count_d;
    logic                  tc_q, tc_d;
    logic                  done_q, done_d;
    logic [PRESCALE_W-1:0] pre_cnt_q, pre_cnt_d;

    logic tick;
    logic step;
    logic at_term;

    assign tick    = enable && (pre_cnt_q == prescale);
    assign step    = tick && !((mode == MODE_ONCE) && done_q);
    assign at_term = up_down ? (count_q >= limit) : (count_q == '0);

    always_comb begin
        count_d   = count_q;
        tc_d      = 1'b0;
        done_d    = done_q;
        pre_cnt_d = pre_cnt_q;

        if (clear) begin
            count_d   = '0;
            done_d    = 1'b0;
            pre_cnt_d = '0;
        end else if (load) begin
            count_d   = load_value;
            done_d    = 1'b0;
            pre_cnt_d = '0;
        end else begin
            // Prescaler keeps running while done so a reload restarts cleanly from 0.
            if (enable) begin
                pre_cnt_d = tick ? '0 : pre_cnt_q + PRESCALE_W'(1);
            end
            if (step) begin
                if (!at_term) begin
                    count_d = up_down ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
                end else begin
                    tc_d = 1'b1;
                    case (mode)
                        MODE_SAT:  count_d = count_q;
                        MODE_ONCE: done_d  = 1'b1;
                        default:   count_d = up_down ? '0 : limit;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q   <= '0;
            tc_q      <= 1'b0;
            done_q    <= 1'b0;
            pre_cnt_q <= '0;
        end else begin
            count_q   <= count_d;
            tc_q      <= tc_d;
            done_q    <= done_d;
            pre_cnt_q <= pre_cnt_d;
        end
    end

    assign count = count_q;
    assign tc    = tc_q;
    assign done  = done_q;

endmodule

// File: tb/tb_prog_counter.sv
// Vector table plus scoreboard bench for prog_counter (WIDTH=8, PRESCALE_W=4).
module tb_prog_counter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       clear = 1'b0;
    logic       load = 1'b0;
    logic [7:0] load_value = '0;
    logic       up_down = 1'b1;
    logic [1:0] mode = 2'b00;
    logic [7:0] limit = '0;
    logic [3:0] prescale = '0;
    logic [7:0] count;
    logic       tc;
    logic       done;

    prog_counter #(.WIDTH(8), .PRESCALE_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .clear      (clear),
        .load       (load),
        .load_value (load_value),
        .up_down    (up_down),
        .mode       (mode),
        .limit      (limit),
        .prescale   (prescale),
        .count      (count),
        .tc         (tc),
        .done       (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       clr;
        bit       ld;
        bit [7:0] lv;
        bit       en;
        bit       ud;
        bit [1:0] md;
        bit [7:0] lim;
        bit [3:0] ps;
        bit [7:0] exp_count;
        bit       exp_tc;
        bit       exp_done;
    } vec_t;

    typedef struct {
        int       idx;
        bit [7:0] count;
        bit       tc;
        bit       done;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic vec_t mk(bit clr, bit ld, bit [7:0] lv, bit en, bit ud, bit [1:0] md,
                                bit [7:0] lim, bit [3:0] ps, bit [7:0] ec, bit et, bit ed);
        vec_t v;
        v.clr = clr; v.ld = ld; v.lv = lv; v.en = en; v.ud = ud; v.md = md;
        v.lim = lim; v.ps = ps; v.exp_count = ec; v.exp_tc = et; v.exp_done = ed;
        return v;
    endfunction

    task automatic check(string name, int idx, int act, int req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s [%0d]: got 0x%0h, expected 0x%0h", name, idx, act, req);
        end
    endtask

    // Drive one vector just after an edge, then compare on the following edge.
    task automatic apply(int idx, vec_t v);
        exp_t e;
        exp_t got;
        clear = v.clr; load = v.ld; load_value = v.lv; enable = v.en;
        up_down = v.ud; mode = v.md; limit = v.lim; prescale = v.ps;
        e.idx = idx; e.count = v.exp_count; e.tc = v.exp_tc; e.done = v.exp_done;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check("scoreboard_empty", idx, 0, 1);
        end else begin
            got = sb.pop_front();
            check("count", got.idx, int'(count), int'(got.count));
            check("tc",    got.idx, int'(tc),    int'(got.tc));
            check("done",  got.idx, int'(done),  int'(got.done));
        end
    endtask

    initial begin
        // Up wrap, limit 5, prescale 0
        for (int i = 0; i < 8; i++) begin
            bit [7:0] c;
            c = 8'((i + 1) % 6);
            vecs.push_back(mk(0, 0, 0, 1, 1, 2'b00, 5, 0, c, (i == 5), 0));
        end
        // Down wrap, limit 3, from 2
        vecs.push_back(mk(0, 1, 2, 0, 0, 2'b00, 3, 0, 2, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 2'b00, 3, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 2'b00, 3, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 2'b00, 3, 0, 3, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 2'b00, 3, 0, 2, 0, 0));
        // Up saturate, limit 4, from 3
        vecs.push_back(mk(0, 1, 3, 0, 1, 2'b01, 4, 0, 3, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 2'b01, 4, 0, 4, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 2'b01, 4, 0, 4, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 2'b01, 4, 0, 4, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 2'b01, 4, 0, 4, 1, 0));
        // One-shot, limit 2, prescale 1
        vecs.push_back(mk(1, 0, 0, 0, 1, 2'b10, 2, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 2'b10, 2, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 2'b10, 2, 1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 2'b10, 2, 1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 2'b10, 2, 1, 2, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 2'b10, 2, 1, 2, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 2'b10, 2, 1, 2, 1, 1));
        vecs.push_back(mk(0, 0, 0, 1, 1, 2'b10, 2, 1, 2, 0, 1));
        vecs.push_back(mk(0, 0, 0, 1, 1, 2'b10, 2, 1, 2, 0, 1));
        vecs.push_back(mk(0, 1, 0, 0, 1, 2'b10, 2, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 2'b10, 2, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 2'b10, 2, 1, 1, 0, 0));
        // Clear beats load; prescale 2 with enable gaps
        vecs.push_back(mk(1, 1, 8'h55, 0, 1, 2'b00, 8'hFF, 2, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 2'b00, 8'hFF, 2, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 2'b00, 8'hFF, 2, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 2'b00, 8'hFF, 2, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 2'b00, 8'hFF, 2, 1, 0, 0));
        // Full-range limit wrap
        vecs.push_back(mk(0, 1, 8'hFE, 0, 1, 2'b00, 8'hFF, 0, 8'hFE, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 2'b00, 8'hFF, 0, 8'hFF, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 2'b00, 8'hFF, 0, 8'h00, 1, 0));
        // Loaded above limit: next step is terminal
        vecs.push_back(mk(0, 1, 9, 0, 1, 2'b00, 5, 0, 9, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 2'b00, 5, 0, 0, 1, 0));
        // Down wrap from 0 to 0x7F with tc high, ahead of the async reset
        vecs.push_back(mk(0, 1, 0, 0, 0, 2'b00, 8'h7F, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 2'b00, 8'h7F, 0, 8'h7F, 1, 0));

        repeat (2) @(posedge clk);
        #1;
        check("reset_count", -1, int'(count), 0);
        check("reset_tc",    -1, int'(tc),    0);
        check("reset_done",  -1, int'(done),  0);
        reset = 1'b0;

        foreach (vecs[i]) apply(i, vecs[i]);

        // Reset mid-cycle must clear outputs before the next edge
        enable = 1'b0;
        #3;
        reset = 1'b1;
        #1;
        check("async_count", -2, int'(count), 0);
        check("async_tc",    -2, int'(tc),    0);
        check("async_done",  -2, int'(done),  0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        apply(1000, mk(0, 0, 0, 1, 1, 2'b00, 5, 0, 1, 0, 0));
        apply(1001, mk(0, 0, 0, 1, 1, 2'b00, 5, 0, 2, 0, 0));

        check("scoreboard_drained", -3, sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/prog_counter.md
Name: prog_counter

Overview:
- Parametrised up/down counter/timer with a programmable terminal value, a clock-enable prescaler and three end-of-count modes (wrap, saturate, one-shot).
- Sits alongside the datapath blocks as the general event counter and interval timer for the bench and for control logic.
- Adds synchronous clear, parallel load, a terminal-count pulse and a done flag on top of a simple enable counter.

Parameters:
- WIDTH, 8, bit width of count, limit and load_value.
- PRESCALE_W, 4, bit width of the prescale divider setting.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  advances the prescaler; counting is frozen when low.
- clear  input  1  synchronous clear of the counter state.
- load  input  1  synchronous parallel load.
- load_value  input  WIDTH  value written to count on load.
- up_down  input  1  count direction: 1 = up, 0 = down.
- mode  input  2  end-of-count behaviour: 00 wrap, 01 saturate, 10 one-shot, 11 reserved (behaves as wrap).
- limit  input  WIDTH  terminal value for up counting; reload value for down counting.
- prescale  input  PRESCALE_W  a step occurs every prescale+1 enabled cycles.
- count  output  WIDTH  current count (registered).
- tc  output  1  one-cycle terminal-count pulse (registered).
- done  output  1  sticky one-shot completion flag (registered).

Behaviour:
- Reset (async, active-high): count=0, tc=0, done=0, prescaler counter pre_cnt=0.
- Priority each cycle: reset > clear > load > step.
- clear: count<=0, done<=0, pre_cnt<=0, tc<=0.
- load: count<=load_value, done<=0, pre_cnt<=0, tc<=0.
- Prescaler:
  - pre_cnt advances only while enable=1.
  - When enable=1 and pre_cnt==prescale: tick=1 and pre_cnt<=0.
  - prescale=0 gives a tick on every enabled cycle.
  - If prescale is lowered below pre_cnt, pre_cnt wraps to 0 via its natural width overflow. No tick is guaranteed until it returns to prescale.
- step = tick AND NOT (mode==10 AND done).
- Terminal test:
  - Up: at_term = (count >= limit).
  - Down: at_term = (count == 0).
- Step with at_term=0: count<=count+1 (up) or count-1 (down), tc<=0.
- Step with at_term=1: tc<=1 for exactly one cycle, then:
  - wrap: up gives count<=0; down gives count<=limit.
  - saturate: count holds. tc re-pulses on every further step while count stays at the terminal value.
  - one-shot: count holds and done<=1. Further ticks are ignored until clear or load.
- tc is 0 in every cycle not directly following a terminal step. tc is never high two consecutive cycles when prescale>0.
- Arithmetic is WIDTH-bit modulo 2^WIDTH. limit = 2^WIDTH-1 gives a full-range counter.
- Loading a value above limit in up mode: the next step is a terminal step (wrap to 0, saturate hold, or one-shot done).
- Changes to up_down, mode and limit apply from the next step. No internal state is flushed.
- Reset asserted mid-count: immediate return to reset values. Counting resumes on the first enabled cycle after release.
- Latency: count, tc and done update on the clk edge at which the step, clear or load is sampled.

Test Plan:
- WIDTH=8, limit=5, up, wrap, prescale=0, enable=1 for 8 cycles after reset release -> count 1,2,3,4,5,0,1,2; tc high only in the cycle count shows 0.
- Down, wrap, limit=3, load_value=2 then enable -> count 2,1,0,3,2; tc high with the first 3.
- Up, saturate, limit=4, load 3, enable 4 cycles -> count 4,4,4,4; tc low, high, high, high.
- One-shot, up, limit=2, prescale=1, enable continuously from count=0 -> count changes every 2 cycles: 1, then 2, then done=1 with count held at 2. Pulse load with load_value=0 -> done=0 and counting restarts.
- load and clear asserted in the same cycle with load_value=0x55 -> count=0. enable toggled 1,0,1 with prescale=2 -> a step only on the 3rd enabled cycle.
- Assert reset asynchronously mid-cycle at count=0x7F with tc high -> count, tc and done go to 0 before the next clk edge.
